// File: rtl/ws2812_refresh_sched.sv
// Frame scheduler for a WS2812 chain: paces frames off a refresh timer, streams
// pixels from the displayed RAM bank to the serializer and holds the reset latch.
module ws2812_refresh_sched #(
    parameter int FRAME_PERIOD = 833333,
    parameter int LATCH_CYCLES = 15000,
    parameter int IDX_W        = 12
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             enable,
    input  logic [IDX_W-1:0] num_leds,
    input  logic             frame_done,
    output logic             swap_ack,
    output logic             disp_bank,
    output logic             mem_rd_en,
    output logic [IDX_W:0]   mem_rd_addr,
    input  logic [23:0]      mem_rd_data,
    output logic             px_valid,
    input  logic             px_ready,
    output logic [23:0]      px_data,
    output logic             px_last,
    input  logic             tx_busy,
    output logic             busy,
    output logic [7:0]       overrun_cnt
);
    localparam int TW = (FRAME_PERIOD > 1) ? $clog2(FRAME_PERIOD) : 1;
    localparam int LW = (LATCH_CYCLES > 1) ? $clog2(LATCH_CYCLES) : 1;

    typedef enum logic [2:0] {
        IDLE, WAIT_TICK, FETCH, WAIT_RD, PRESENT, DRAIN, LATCH
    } state_t;

    state_t           state;
    logic [TW-1:0]    tcnt;
    logic             tick;
    logic [LW-1:0]    lcnt;
    logic [IDX_W-1:0] idx;
    logic [IDX_W-1:0] n_lat;
    logic             swap_pend;

    assign tick = enable && (tcnt == TW'(FRAME_PERIOD - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tcnt <= '0;
        end else if (!enable || tick) begin
            tcnt <= '0;
        end else begin
            tcnt <= tcnt + TW'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            swap_ack    <= 1'b0;
            disp_bank   <= 1'b0;
            mem_rd_en   <= 1'b0;
            mem_rd_addr <= '0;
            px_valid    <= 1'b0;
            px_data     <= '0;
            px_last     <= 1'b0;
            busy        <= 1'b0;
            overrun_cnt <= '0;
            swap_pend   <= 1'b0;
            lcnt        <= '0;
            idx         <= '0;
            n_lat       <= '0;
        end else begin
            swap_ack  <= 1'b0;
            mem_rd_en <= 1'b0;
            if (frame_done) swap_pend <= 1'b1;
            // busy tracks every state that cannot accept a tick
            if (tick && busy && overrun_cnt != 8'hFF) overrun_cnt <= overrun_cnt + 8'd1;

            case (state)
                IDLE, WAIT_TICK: begin
                    if (tick && num_leds != '0) begin
                        n_lat       <= num_leds;
                        idx         <= '0;
                        mem_rd_en   <= 1'b1;
                        mem_rd_addr <= {disp_bank ^ swap_pend, {IDX_W{1'b0}}};
                        busy        <= 1'b1;
                        state       <= FETCH;
                        if (swap_pend) begin
                            disp_bank <= ~disp_bank;
                            swap_ack  <= 1'b1;
                            // a frame_done landing on the swap edge stays pending
                            swap_pend <= frame_done;
                        end
                    end else if (!enable) begin
                        state <= IDLE;
                    end
                end
                FETCH: state <= WAIT_RD;
                WAIT_RD: begin
                    px_data  <= mem_rd_data;
                    px_last  <= (idx == n_lat - IDX_W'(1));
                    px_valid <= 1'b1;
                    state    <= PRESENT;
                end
                PRESENT: begin
                    if (px_ready) begin
                        px_valid <= 1'b0;
                        if (px_last) begin
                            state <= DRAIN;
                        end else begin
                            idx         <= idx + IDX_W'(1);
                            mem_rd_en   <= 1'b1;
                            mem_rd_addr <= {disp_bank, idx + IDX_W'(1)};
                            state       <= FETCH;
                        end
                    end
                end
                DRAIN: begin
                    if (!tx_busy) begin
                        lcnt  <= '0;
                        state <= LATCH;
                    end
                end
                LATCH: begin
                    if (lcnt == LW'(LATCH_CYCLES - 1)) begin
                        busy  <= 1'b0;
                        state <= enable ? WAIT_TICK : IDLE;
                    end else begin
                        lcnt <= lcnt + LW'(1);
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: doc/ws2812_refresh_sched.md
# ws2812_refresh_sched

Frame scheduler for the WS2812 LED chain. It fetches pixels from a double-banked frame RAM filled by the UART/FIFO path and presents them to the bit serializer through a valid/ready handshake. It paces frames with a free-running refresh timer and enforces the reset-latch low time after each frame. It swaps the display bank only at frame boundaries, so the host never tears a frame.

## Interface
Parameters:
- `FRAME_PERIOD`, 833333: clocks between refresh ticks (60 Hz at 50 MHz).
- `LATCH_CYCLES`, 15000: minimum idle clocks after the last bit, i.e. the reset latch (300 µs at 50 MHz).
- `IDX_W`, 12: pixel index width; matches the `num_leds` width.

Ports:
- `clk`, in, 1: single clock, all logic rising-edge.
- `rst_n`, in, 1: asynchronous active-low reset.
- `enable`, in, 1: refresh enable, level.
- `num_leds`, in, IDX_W: chain length, sampled at frame start.
- `frame_done`, in, 1: one-cycle pulse from the writer; the back bank is complete.
- `swap_ack`, out, 1: one-cycle pulse when a bank swap is taken.
- `disp_bank`, out, 1: bank currently displayed; the writer uses `~disp_bank`.
- `mem_rd_en`, out, 1: RAM read strobe.
- `mem_rd_addr`, out, IDX_W+1: {disp_bank, pixel index}.
- `mem_rd_data`, in, 24: GRB word, valid the cycle after `mem_rd_en`.
- `px_valid`, out, 1: pixel offered to the serializer.
- `px_ready`, in, 1: serializer accepts the pixel.
- `px_data`, out, 24: pixel word, registered.
- `px_last`, out, 1: qualifies the final pixel of a frame.
- `tx_busy`, in, 1: serializer still shifting bits.
- `busy`, out, 1: high in every state except IDLE and WAIT_TICK.
- `overrun_cnt`, out, 8: saturating count of missed ticks.

## Operation
- Tick timer: counts 0..FRAME_PERIOD-1 while `enable`=1. It is held at 0 while `enable`=0. `tick` pulses when the count wraps to 0.
- `swap_pend` is set by `frame_done` and cleared when a swap is taken.
- State machine, 7 states:
  - **IDLE / WAIT_TICK**: on `tick` with `enable`=1:
    - if `num_leds`=0, stay in the state and take no swap;
    - otherwise latch `num_leds` into `n_lat` and set idx=0.
    - If `swap_pend` is set, toggle `disp_bank`, pulse `swap_ack` and clear `swap_pend`.
    - Go to FETCH.
  - **FETCH**: `mem_rd_en`=1 with `mem_rd_addr`={disp_bank, idx} for exactly one cycle, then go to WAIT_RD.
  - **WAIT_RD**: capture `mem_rd_data` into `px_data`; set `px_last` = (idx == n_lat-1); go to PRESENT.
  - **PRESENT**: `px_valid`=1, with `px_data` and `px_last` held stable until `px_ready`. On handshake:
    - if `px_last`, go to DRAIN;
    - otherwise idx+1 and go to FETCH.
  - **DRAIN**: wait for `tx_busy`=0, then clear the latch counter and go to LATCH.
  - **LATCH**: count LATCH_CYCLES clocks. Then go to WAIT_TICK if `enable`=1, else IDLE.
- `frame_done` arriving in the same cycle as a frame-start swap is not consumed. `swap_pend` stays set for the next frame.
- Deasserting `enable` mid-frame does not truncate: the frame, DRAIN and LATCH complete first.
- Overrun: a `tick` seen in FETCH, WAIT_RD, PRESENT, DRAIN or LATCH increments `overrun_cnt`, saturating at 255. The tick is dropped, not queued.
- Widths: idx and `n_lat` are IDX_W bits. The comparison `n_lat-1` is done at IDX_W bits; `n_lat`=0 is excluded at start.
- Reset values: `disp_bank`=0, `swap_ack`=0, `mem_rd_en`=0, `mem_rd_addr`=0, `px_valid`=0, `px_data`=0, `px_last`=0, `busy`=0, `overrun_cnt`=0, state IDLE, `swap_pend`=0, timer 0.
- Reset mid-frame: `px_valid` drops asynchronously and nothing resumes.

## Timing
- Tick to `mem_rd_en`: 1 cycle, since FETCH is entered on the cycle after `tick`.
- Per pixel: FETCH, then WAIT_RD, then PRESENT. The minimum is 3 cycles/pixel when `px_ready` is held high; the serializer needs about 1500 cycles per pixel, so this is never the bottleneck.
- `px_valid` rises 2 cycles after `mem_rd_en`. It falls the cycle after the `px_ready` handshake.
- `swap_ack` is asserted in the cycle that FETCH is entered. `disp_bank` changes in that same edge, so the first read already uses the new bank.
- The last handshake to the end of LATCH spans the DRAIN duration plus LATCH_CYCLES.
- No combinational path from `px_ready` to `px_valid`.

## Test plan
- FRAME_PERIOD=200, LATCH_CYCLES=20, `num_leds`=3, `px_ready`=1, `tx_busy`=0:
  - expect `mem_rd_addr` 0,1,2 and `px_data` equal to the RAM words;
  - expect `px_last` only on pixel 2;
  - expect LATCH for 20 cycles, then WAIT_TICK.
- Pulse `frame_done` mid-frame:
  - no `swap_ack` until the next tick;
  - then `swap_ack`=1 and `disp_bank` 0→1;
  - first `mem_rd_addr`=0x1000 (IDX_W=12).
- Backpressure: hold `px_ready`=0 for 10 cycles on pixel 1 → `px_valid` and `px_data` stay stable; no further `mem_rd_en`.
- Overrun: hold `tx_busy`=1 for 450 cycles in DRAIN → `overrun_cnt`=2; the next frame starts on the following tick.
- Set `num_leds`=0 → no `mem_rd_en` ever, `busy`=0. Then assert `rst_n`=0 mid-PRESENT → `px_valid`=0 immediately and all outputs hold their reset values.
